gpio_axil_seq: RTL

GPIO_AXIL_SEQ -- requirements
Module: gpio_axil_seq

---
 rtl/gpio_axil_seq.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/gpio_axil_seq.sv
// One-hot LED sequencer driving an AXI GPIO over AXI4-Lite: configures both channels as outputs, then
// writes pattern/reversed pattern per tick. Define GPIO_SEQ_RDBK_EN to read back and verify channel 1.
module gpio_axil_seq #(
  parameter int         NLED = 3,
  parameter logic [8:0] BASE = 9'h000
) (
  input  logic            clk100,
  input  logic            rst,
  input  logic            en_i,
  input  logic            tick_i,
  output logic [8:0]      m_axi_awaddr,
  output logic [2:0]      m_axi_awprot,
  output logic            m_axi_awvalid,
  input  logic            m_axi_awready,
  output logic [31:0]     m_axi_wdata,
  output logic [3:0]      m_axi_wstrb,
  output logic            m_axi_wvalid,
  input  logic            m_axi_wready,
  input  logic [1:0]      m_axi_bresp,
  input  logic            m_axi_bvalid,
  output logic            m_axi_bready,
  output logic [8:0]      m_axi_araddr,
  output logic [2:0]      m_axi_arprot,
  output logic            m_axi_arvalid,
  input  logic            m_axi_arready,
  input  logic [31:0]     m_axi_rdata,
  input  logic [1:0]      m_axi_rresp,
  input  logic            m_axi_rvalid,
  output logic            m_axi_rready,
  output logic [NLED-1:0] pattern_o,
  output logic            busy_o,
  output logic            err_o,
  output logic            mismatch_o,
  output logic [7:0]      step_cnt_o
);

  typedef enum logic [2:0] {CFG_TRI1, CFG_TRI2, IDLE, WR_D1, WR_D2, RD_D1, RD_WAIT} state_t;

  state_t          state, state_d, wr_next;
  logic            act, act_d, tick_q, tick_rise, pending, pending_d;
  logic            awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic            err_d, mismatch_d, busy_d;
  logic [8:0]      awaddr_d, araddr_d, wr_addr;
  logic [31:0]     wdata_d, wr_data;
  logic [NLED-1:0] pattern_d, pattern_rot, pattern_rev;
  logic [7:0]      step_cnt_d;
  logic            unused_rd;

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = 4'hF;
  assign tick_rise    = tick_i & ~tick_q;
  assign pattern_rot  = {pattern_o[NLED-2:0], pattern_o[NLED-1]};
  assign unused_rd    = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};

  always_comb begin
    for (int i = 0; i < NLED; i++) pattern_rev[i] = pattern_o[NLED-1-i];
  end

  always_comb begin
    wr_addr = BASE + 9'h004;
    wr_data = '0;
    wr_next = CFG_TRI2;
    case (state)
      CFG_TRI2: begin
        wr_addr = BASE + 9'h00C;
        wr_next = IDLE;
      end
      WR_D1: begin
        wr_addr = BASE;
        wr_data = {{(32-NLED){1'b0}}, pattern_o};
        wr_next = WR_D2;
      end
      WR_D2: begin
        wr_addr = BASE + 9'h008;
        wr_data = {{(32-NLED){1'b0}}, pattern_rev};
`ifdef GPIO_SEQ_RDBK_EN
        wr_next = RD_D1;
`else
        wr_next = IDLE;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state;
    act_d      = act;
    awvalid_d  = m_axi_awvalid;
    wvalid_d   = m_axi_wvalid;
    bready_d   = m_axi_bready;
    arvalid_d  = m_axi_arvalid;
    rready_d   = m_axi_rready;
    awaddr_d   = m_axi_awaddr;
    araddr_d   = m_axi_araddr;
    wdata_d    = m_axi_wdata;
    pattern_d  = pattern_o;
    step_cnt_d = step_cnt_o;
    err_d      = err_o;
    mismatch_d = mismatch_o;
    // Edges outside IDLE collapse into one pending request.
    pending_d  = pending | (tick_rise & (state != IDLE));
    case (state)
      CFG_TRI1, CFG_TRI2, WR_D1, WR_D2: begin
        if (!act) begin
          act_d     = 1'b1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = wr_addr;
          wdata_d   = wr_data;
        end else if (m_axi_bready) begin
          if (m_axi_bvalid) begin
            bready_d = 1'b0;
            act_d    = 1'b0;
            state_d  = wr_next;
            if (m_axi_bresp != 2'b00) err_d = 1'b1;
            if (state == WR_D2) step_cnt_d = step_cnt_o + 8'd1;
          end
        end else begin
          if (m_axi_awvalid && m_axi_awready) awvalid_d = 1'b0;
          if (m_axi_wvalid && m_axi_wready) wvalid_d = 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) bready_d = 1'b1;
        end
      end
      IDLE: begin
        if (en_i && (tick_rise || pending)) begin
          pending_d = 1'b0;
          pattern_d = pattern_rot;
          state_d   = WR_D1;
        end
      end
`ifdef GPIO_SEQ_RDBK_EN
      RD_D1: begin
        if (!act) begin
          act_d     = 1'b1;
          arvalid_d = 1'b1;
          araddr_d  = BASE;
        end else if (m_axi_arready) begin
          act_d     = 1'b0;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          state_d  = IDLE;
          if (m_axi_rresp != 2'b00) err_d = 1'b1;
          if (m_axi_rdata[NLED-1:0] != pattern_o) mismatch_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state         <= CFG_TRI1;
      act           <= 1'b0;
      tick_q        <= 1'b0;
      pending       <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_araddr  <= '0;
      m_axi_wdata   <= '0;
      pattern_o     <= {{(NLED-1){1'b0}}, 1'b1};
      step_cnt_o    <= '0;
      err_o         <= 1'b0;
      mismatch_o    <= 1'b0;
      busy_o        <= 1'b1;
    end else begin
      state         <= state_d;
      act           <= act_d;
      tick_q        <= tick_i;
      pending       <= pending_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_bready  <= bready_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_rready  <= rready_d;
      m_axi_awaddr  <= awaddr_d;
      m_axi_araddr  <= araddr_d;
      m_axi_wdata   <= wdata_d;
      pattern_o     <= pattern_d;
      step_cnt_o    <= step_cnt_d;
      err_o         <= err_d;
      mismatch_o    <= mismatch_d;
      busy_o        <= busy_d;
    end
  end

endmodule
